// File: rtl/rx_path.sv
// Serial frame receiver: start, WIDTH_SIZE data bits LSB first, even parity (single or per byte), stop.
// Latency: valid pulses one cycle after the synchronized stop-bit sample; no backpressure, every pulse must be taken.
module rx_path #(
  parameter int WIDTH_SIZE  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  PF,
  output logic [WIDTH_SIZE-1:0] data_out,
  output logic                  valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int                IDX_W       = $clog2(WIDTH_SIZE + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(WIDTH_SIZE - 1);
  localparam logic [IDX_W-1:0]  END_IDX     = IDX_W'(WIDTH_SIZE);
  localparam bit                MULTI_CHUNK = (WIDTH_SIZE > 8);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} state_t;

  state_t                  state_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [WIDTH_SIZE-1:0]   shift_q;
  logic [IDX_W-1:0]        idx_q;
  logic [2:0]              cnt_q;
  logic                    par_q;
  logic                    err_q;
  logic                    pf_q;
  logic                    rx_s;
  logic                    chunk_end;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign busy      = (state_q != IDLE);
  // A chunk ending on the last data bit yields a single parity slot, since both terms only pick PARITY.
  assign chunk_end = (idx_q == LAST_IDX) || (pf_q && MULTI_CHUNK && (cnt_q == 3'd7));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= rx;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      err_q      <= 1'b0;
      pf_q       <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= DATA;
            idx_q   <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            pf_q    <= PF;
          end
        end
        DATA: begin
          for (int i = 0; i < WIDTH_SIZE; i++) begin
            if (idx_q == IDX_W'(i)) shift_q[i] <= rx_s;
          end
          idx_q <= idx_q + IDX_W'(1);
          cnt_q <= cnt_q + 3'd1;
          par_q <= par_q ^ rx_s;
          if (chunk_end) state_q <= PARITY;
        end
        PARITY: begin
          if (rx_s != par_q) err_q <= 1'b1;
          par_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= (idx_q == END_IDX) ? STOP : DATA;
        end
        STOP: begin
          data_out   <= shift_q;
          parity_err <= err_q;
          frame_err  <= !rx_s;
          valid      <= 1'b1;
          state_q    <= rx_s ? IDLE : BREAK;
        end
        BREAK: begin
          // A held-low line must not be mistaken for a stream of start bits.
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_path.sv
// Directed bench for rx_path: 8-bit and 16-bit instances on a shared clock and reset.
module tb_rx_path;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx8, rx16, pf8, pf16;
  logic [7:0]  data8;
  logic [15:0] data16;
  logic        valid8, perr8, ferr8, busy8;
  logic        valid16, perr16, ferr16, busy16;

  int n_cmp = 0;
  int n_mis = 0;

  int          v8_cnt = 0;
  int          v16_cnt = 0;
  logic [7:0]  d8q[$];
  logic        pe8, fe8, pe16, fe16;
  logic [15:0] d16;
  logic        prev_v8 = 1'b0;
  int          base;

  always #5 clk = ~clk;

  rx_path #(.WIDTH_SIZE(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .reset(rst_n), .rx(rx8), .PF(pf8),
    .data_out(data8), .valid(valid8), .parity_err(perr8), .frame_err(ferr8), .busy(busy8)
  );

  rx_path #(.WIDTH_SIZE(16), .SYNC_STAGES(2)) u_dut16 (
    .clk(clk), .reset(rst_n), .rx(rx16), .PF(pf16),
    .data_out(data16), .valid(valid16), .parity_err(perr16), .frame_err(ferr16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (valid8) begin
      check("v8_single_cycle", {31'b0, prev_v8}, 32'd0);
      v8_cnt++;
      d8q.push_back(data8);
      pe8 = perr8;
      fe8 = ferr8;
    end
    prev_v8 = valid8;
    if (valid16) begin
      v16_cnt++;
      d16  = data16;
      pe16 = perr16;
      fe16 = ferr16;
    end
  end

  function automatic logic [31:0] f8(input logic [7:0] d, input logic pflip, input logic stop);
    return {21'b0, stop, (^d) ^ pflip, d, 1'b0};
  endfunction

  function automatic logic [31:0] f16pb(input logic [15:0] d, input logic f0, input logic f1);
    return {12'b0, 1'b1, (^d[15:8]) ^ f1, d[15:8], (^d[7:0]) ^ f0, d[7:0], 1'b0};
  endfunction

  function automatic logic [31:0] f16sp(input logic [15:0] d);
    return {13'b0, 1'b1, ^d, d, 1'b0};
  endfunction

  task automatic send(input int sel, input logic [31:0] bits, input int n, input int pf_drop_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == pf_drop_at) pf16 = 1'b0;
      if (sel == 8) rx8 = bits[i];
      else rx16 = bits[i];
    end
  endtask

  task automatic gap(input int k);
    repeat (k) begin
      @(negedge clk);
      rx8  = 1'b1;
      rx16 = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx8 = 1'b1; rx16 = 1'b1; pf8 = 1'b0; pf16 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data8", {24'b0, data8}, 32'd0);
    check("rst_valid8", {31'b0, valid8}, 32'd0);
    check("rst_errs8", {30'b0, perr8, ferr8}, 32'd0);
    check("rst_busy", {30'b0, busy8, busy16}, 32'd0);
    check("rst_data16", {16'b0, data16}, 32'd0);
    rst_n = 1'b1;
    gap(4);

    // A5, single parity
    base = v8_cnt;
    send(8, f8(8'hA5, 1'b0, 1'b1), 11, -1);
    gap(6);
    check("a5_count", v8_cnt - base, 32'd1);
    check("a5_data", {24'b0, d8q[$]}, 32'hA5);
    check("a5_errs", {30'b0, pe8, fe8}, 32'd0);
    check("a5_busy_idle", {31'b0, busy8}, 32'd0);

    // Reset in the middle of a frame discards it
    base = v8_cnt;
    send(8, f8(8'h5A, 1'b0, 1'b1), 6, -1);
    check("mid_busy", {31'b0, busy8}, 32'd1);
    #3 rst_n = 1'b0;
    #2;
    check("mid_rst_data", {24'b0, data8}, 32'd0);
    check("mid_rst_busy", {31'b0, busy8}, 32'd0);
    check("mid_rst_flags", {29'b0, valid8, perr8, ferr8}, 32'd0);
    rx8 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gap(12);
    check("mid_no_valid", v8_cnt - base, 32'd0);
    send(8, f8(8'h5A, 1'b0, 1'b1), 11, -1);
    gap(6);
    check("post_rst_count", v8_cnt - base, 32'd1);
    check("post_rst_data", {24'b0, d8q[$]}, 32'h5A);

    // 16-bit per-byte parity, second parity inverted
    base = v16_cnt;
    pf16 = 1'b1;
    send(16, f16pb(16'h13F1, 1'b0, 1'b1), 20, -1);
    gap(6);
    check("pb_count", v16_cnt - base, 32'd1);
    check("pb_data", {16'b0, d16}, 32'h13F1);
    check("pb_perr", {31'b0, pe16}, 32'd1);
    check("pb_ferr", {31'b0, fe16}, 32'd0);

    // 16-bit single parity
    base = v16_cnt;
    pf16 = 1'b0;
    send(16, f16sp(16'hBEEF), 19, -1);
    gap(6);
    check("sp_count", v16_cnt - base, 32'd1);
    check("sp_data", {16'b0, d16}, 32'hBEEF);
    check("sp_errs", {30'b0, pe16, fe16}, 32'd0);

    // Stop bit low, then line held low
    base = v8_cnt;
    send(8, f8(8'h3C, 1'b0, 1'b0), 11, -1);
    repeat (20) begin
      @(negedge clk);
      rx8 = 1'b0;
    end
    check("brk_count", v8_cnt - base, 32'd1);
    check("brk_data", {24'b0, d8q[$]}, 32'h3C);
    check("brk_ferr", {31'b0, fe8}, 32'd1);
    check("brk_perr", {31'b0, pe8}, 32'd0);
    check("brk_busy", {31'b0, busy8}, 32'd1);
    gap(4);
    check("brk_exit_busy", {31'b0, busy8}, 32'd0);
    send(8, f8(8'h81, 1'b0, 1'b1), 11, -1);
    gap(6);
    check("brk_next_count", v8_cnt - base, 32'd2);
    check("brk_next_data", {24'b0, data8}, 32'h81);
    check("brk_next_errs", {30'b0, pe8, fe8}, 32'd0);

    // Back-to-back frames, no idle gap
    base = v8_cnt;
    send(8, f8(8'h00, 1'b0, 1'b1), 11, -1);
    send(8, f8(8'hFF, 1'b0, 1'b1), 11, -1);
    gap(6);
    check("b2b_count", v8_cnt - base, 32'd2);
    check("b2b_first", {24'b0, d8q[$-1]}, 32'h00);
    check("b2b_second", {24'b0, d8q[$]}, 32'hFF);
    check("b2b_errs", {30'b0, pe8, fe8}, 32'd0);

    // PF dropped mid-frame must not change the layout
    base = v16_cnt;
    pf16 = 1'b1;
    send(16, f16pb(16'h1234, 1'b0, 1'b0), 20, 5);
    gap(6);
    check("pfchg_count", v16_cnt - base, 32'd1);
    check("pfchg_data", {16'b0, d16}, 32'h1234);
    check("pfchg_errs", {30'b0, pe16, fe16}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
